// File: rtl/seq_mult_ctrl.sv
// Shift-and-add unsigned multiplier with start/busy/done handshake and a held, registered product.
// Build option SEQ_MULT_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start; P holds the last product
// RUN   | one multiplier bit consumed per clock
// DONE  | done pulse, P valid; start here launches the next operation directly
module seq_mult_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q,  state_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   p_q,      p_d;

    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier_shifted;
    logic                 last_iter;

    always_comb begin
        acc_sum        = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shifted = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_iter = (cnt_q == CNT_LAST) || (mplier_shifted == '0);
`else
        last_iter = (cnt_q == CNT_LAST);
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shifted;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    // Publish including this edge's add, so P is valid in the DONE cycle.
                    p_d     = acc_sum;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign P    = p_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl (WIDTH=3); honours SEQ_MULT_EARLY_TERM_EN for expected latencies.
module tb_seq_mult_ctrl;

    localparam int W = 3;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int checks = 0;
    int errors = 0;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are settled when this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen; cycles = edges after the accepting edge, or -1 on timeout.
    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            step();
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int l;
        l = 1;
        for (int i = 0; i < W; i++)
            if (b[i]) l = i + 1;
        return l;
`else
        return W;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        step();
        step();
        checks++; if (P !== 6'd0)  begin errors++; $display("FAIL reset_P got %0d want 0", P); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (P !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d got P=%0d busy=%b done=%b want 0/0/0", i, P, busy, done);
            end
        end
    endtask

    task automatic test_basic();
        A = 3'd7; B = 3'd7; start = 1'b1;
        step();
        start = 1'b0; A = '0; B = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_k got %b want 1", busy); end
        for (int e = 1; e <= 3; e++) begin
            if (e > 1 || W > 3) begin end
`ifdef SEQ_MULT_EARLY_TERM_EN
            // B=7 has its top bit set, so early termination does not shorten this run.
`endif
            if (e < 3) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL basic_run edge k+%0d got done=%b busy=%b want 0/1", e - 1, done, busy);
                end
            end
            step();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_k3 got %b want 1", done); end
        checks++; if (P !== 6'd49)   begin errors++; $display("FAIL basic_P got %0d want 49", P); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_k4 got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_k4 got %b want 0", busy); end
        step();
        checks++; if (P !== 6'd49)   begin errors++; $display("FAIL basic_P_hold got %0d want 49", P); end
    endtask

    task automatic test_exhaustive();
        int cyc;
        int prod;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                A = W'(a); B = W'(b); start = 1'b1;
                step();
                start = 1'b0;
                wait_done(10, cyc);
                prod = a * b;
                checks++;
                if (cyc !== exp_latency(W'(b))) begin
                    errors++; $display("FAIL exh_latency %0d*%0d got %0d want %0d", a, b, cyc, exp_latency(W'(b)));
                end
                checks++;
                if (P !== 6'(prod)) begin
                    errors++; $display("FAIL exh_P %0d*%0d got %0d want %0d", a, b, P, prod);
                end
                step();
                checks++;
                if (done !== 1'b0) begin
                    errors++; $display("FAIL exh_done_width %0d*%0d got done=%b want 0", a, b, done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        A = 3'd5; B = 3'd6; start = 1'b1;
        step();
        A = 3'd2; B = 3'd3;
        for (int e = 1; e <= 2; e++) begin
            step();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL b2b_ignored_start edge k+%0d got done=%b want 0", e, done); end
        end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
        checks++; if (P !== 6'd30)   begin errors++; $display("FAIL b2b_first_P got %0d want 30", P); end
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || P !== 6'd30) begin
            errors++; $display("FAIL b2b_relaunch got done=%b busy=%b P=%0d want 0/1/30", done, busy, P);
        end
        wait_done(10, cyc);
        checks++;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (cyc !== 2) begin errors++; $display("FAIL b2b_second_latency got %0d want 2", cyc); end
`else
        if (cyc !== 3) begin errors++; $display("FAIL b2b_second_latency got %0d want 3", cyc); end
`endif
        checks++; if (P !== 6'd6) begin errors++; $display("FAIL b2b_second_P got %0d want 6", P); end
        step();
    endtask

    task automatic test_reset_mid();
        int cyc;
        A = 3'd6; B = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || P !== 6'd0) begin
            errors++; $display("FAIL rstmid_state got done=%b busy=%b P=%0d want 0/0/0", done, busy, P);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || P !== 6'd0) begin
                errors++; $display("FAIL rstmid_idle cyc %0d got done=%b busy=%b P=%0d want 0/0/0", i, done, busy, P);
            end
        end
        A = 3'd3; B = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(10, cyc);
        checks++;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (cyc !== 2) begin errors++; $display("FAIL rstmid_after_latency got %0d want 2", cyc); end
`else
        if (cyc !== 3) begin errors++; $display("FAIL rstmid_after_latency got %0d want 3", cyc); end
`endif
        checks++; if (P !== 6'd9) begin errors++; $display("FAIL rstmid_after_P got %0d want 9", P); end
        step();
    endtask

    task automatic test_early_term();
        int cyc;
        int a_v   [3] = '{3, 5, 7};
        int b_v   [3] = '{1, 0, 4};
        int p_v   [3] = '{3, 0, 28};
`ifdef SEQ_MULT_EARLY_TERM_EN
        int lat_v [3] = '{1, 1, 3};
`else
        int lat_v [3] = '{3, 3, 3};
`endif
        for (int i = 0; i < 3; i++) begin
            A = W'(a_v[i]); B = W'(b_v[i]); start = 1'b1;
            step();
            start = 1'b0;
            wait_done(10, cyc);
            checks++;
            if (cyc !== lat_v[i]) begin
                errors++; $display("FAIL eterm_latency %0d*%0d got %0d want %0d", a_v[i], b_v[i], cyc, lat_v[i]);
            end
            checks++;
            if (P !== 6'(p_v[i])) begin
                errors++; $display("FAIL eterm_P %0d*%0d got %0d want %0d", a_v[i], b_v[i], P, p_v[i]);
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        test_reset();
        test_basic();
        test_exhaustive();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
